// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement adder/subtractor. Operands arrive LSB first,
// framed into WORD_LEN-bit words; the result leaves DELAY cycles later
// together with word-framing strobes and a signed-overflow flag.
//
// Parameters
//   WORD_LEN   : bits per word (2..64), MSB is the sign bit
//   DELAY      : output pipeline depth in cycles (1..8)
//   CONTINUOUS : 1 = words follow each other automatically,
//                0 = return to idle after each word
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   word_start : marks operand bit 0 (also aborts a word in progress)
//   sub        : 1 = a-b, 0 = a+b; sampled with bit 0
//   a, b       : serial operands, LSB first
//   sum        : serial result bit
//   sum_first  : high with result bit 0
//   sum_last   : high with result bit WORD_LEN-1
//   overflow   : signed overflow, only valid with sum_last
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int unsigned WORD_LEN   = 17,
  parameter int unsigned DELAY      = 2,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic word_start,
  input  logic sub,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic sum_first,
  output logic sum_last,
  output logic overflow
);

  localparam int unsigned CNT_W = (WORD_LEN > 2) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORD_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic sum;
    logic first;
    logic last;
    logic ovf;
  } pipe_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_m;
  pipe_t            r_pipe [DELAY];

  logic             w_active;
  logic             w_bit0;
  logic [CNT_W-1:0] w_k;
  logic             w_last;
  logic             w_m_eff;
  logic             w_b_eff;
  logic             w_cin;
  logic             w_s;
  logic             w_cout;
  pipe_t            w_stage;

  // Bit-time datapath: classify the current cycle and form sum/carry.
  always_comb begin
    w_active = 1'b0;
    w_bit0   = 1'b0;
    w_k      = '0;
    w_last   = 1'b0;
    w_m_eff  = 1'b0;
    w_b_eff  = 1'b0;
    w_cin    = 1'b0;
    w_s      = 1'b0;
    w_cout   = 1'b0;
    w_stage  = '0;

    w_active = (r_state == ST_RUN) || word_start;
    // cnt==0 in RUN is an automatic wrap; word_start forces bit 0 (abort).
    w_bit0   = word_start || (r_cnt == '0);
    w_k      = word_start ? '0 : r_cnt;
    w_last   = w_active && (w_k == LAST_K);

    w_m_eff  = w_bit0 ? sub : r_m;
    w_b_eff  = b ^ w_m_eff;
    // Carry-in at bit 0 is the mode bit: +1 completes the two's complement of b.
    w_cin    = w_bit0 ? w_m_eff : r_c;
    w_s      = a ^ w_b_eff ^ w_cin;
    w_cout   = (a & w_b_eff) | (a & w_cin) | (w_b_eff & w_cin);

    w_stage.sum   = w_active & w_s;
    w_stage.first = w_active & w_bit0;
    w_stage.last  = w_last;
    // Signed overflow: carry into the sign bit differs from carry out of it.
    w_stage.ovf   = w_last & (w_cin ^ w_cout);
  end

  // Control state, carry/mode registers and output pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_m     <= 1'b0;
      for (int i = 0; i < int'(DELAY); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_stage;
      for (int i = 1; i < int'(DELAY); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_active) begin
        r_c <= w_cout;
        r_m <= w_m_eff;
        if (w_last) begin
          r_cnt   <= '0;
          r_state <= CONTINUOUS ? ST_RUN : ST_IDLE;
        end else begin
          r_cnt   <= w_k + CNT_W'(1);
          r_state <= ST_RUN;
        end
      end else begin
        r_c     <= 1'b0;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  assign sum       = r_pipe[DELAY-1].sum;
  assign sum_first = r_pipe[DELAY-1].first;
  assign sum_last  = r_pipe[DELAY-1].last;
  assign overflow  = r_pipe[DELAY-1].ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: one continuous and one non-continuous instance
// share the stimulus; a per-instance monitor reassembles output words and
// compares them against expected words queued by the driver.
module tb_serial_addsub;

  localparam int unsigned WL = 17;
  localparam int unsigned DL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic word_start = 1'b0;
  logic sub = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  logic c_sum, c_first, c_last, c_ovf;
  logic n_sum, n_first, n_last, n_ovf;

  always #5 clk = ~clk;

  serial_addsub #(.WORD_LEN(WL), .DELAY(DL), .CONTINUOUS(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .word_start(word_start), .sub(sub), .a(a), .b(b),
    .sum(c_sum), .sum_first(c_first), .sum_last(c_last), .overflow(c_ovf)
  );

  serial_addsub #(.WORD_LEN(WL), .DELAY(DL), .CONTINUOUS(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .word_start(word_start), .sub(sub), .a(a), .b(b),
    .sum(n_sum), .sum_first(n_first), .sum_last(n_last), .overflow(n_ovf)
  );

  typedef struct {
    logic [WL-1:0] res;
    logic          ovf;
    int            first;
  } exp_t;

  exp_t q_c[$];
  exp_t q_n[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  bit            mon_en [2] = '{1'b1, 1'b1};
  bit            col    [2] = '{1'b0, 1'b0};
  int            idx    [2] = '{0, 0};
  int            fcyc   [2] = '{0, 0};
  logic [WL-1:0] acc    [2];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Reassemble one output word per instance and score it on sum_last.
  task automatic mon_step(input int d, input logic s, input logic f, input logic l, input logic o);
    exp_t e;
    bit   have;
    if (!mon_en[d]) return;
    if (!rst_q) begin
      col[d] = 1'b0;
      return;
    end
    if (f) begin
      col[d]  = 1'b1;
      idx[d]  = 0;
      acc[d]  = '0;
      fcyc[d] = cyc;
    end
    if (o && !l) begin
      checks++; errors++;
      $display("FAIL ovf_outside_last dut%0d cyc %0d: got 1, want 0", d, cyc);
    end
    if (col[d]) begin
      acc[d][idx[d]] = s;
      if (l) begin
        checks++;
        if (idx[d] != int'(WL) - 1) begin
          errors++;
          $display("FAIL last_position dut%0d cyc %0d: got bit %0d, want %0d", d, cyc, idx[d], WL - 1);
        end
        have = (d == 0) ? (q_c.size() != 0) : (q_n.size() != 0);
        if (!have) begin
          checks++; errors++;
          $display("FAIL unexpected_word dut%0d cyc %0d: got word %h, want none", d, cyc, acc[d]);
        end else begin
          if (d == 0) e = q_c.pop_front();
          else        e = q_n.pop_front();
          checks++;
          if (acc[d] !== e.res) begin
            errors++;
            $display("FAIL result dut%0d cyc %0d: got %h, want %h", d, cyc, acc[d], e.res);
          end
          checks++;
          if (o !== e.ovf) begin
            errors++;
            $display("FAIL overflow dut%0d cyc %0d: got %b, want %b", d, cyc, o, e.ovf);
          end
          checks++;
          if (fcyc[d] != e.first) begin
            errors++;
            $display("FAIL first_cycle dut%0d: got %0d, want %0d", d, fcyc[d], e.first);
          end
        end
        col[d] = 1'b0;
      end else begin
        idx[d]++;
        if (idx[d] >= int'(WL)) begin
          checks++; errors++;
          $display("FAIL missing_last dut%0d cyc %0d: got none, want sum_last", d, cyc);
          col[d] = 1'b0;
        end
      end
    end else if (l || s) begin
      checks++; errors++;
      $display("FAIL stray_output dut%0d cyc %0d: got sum=%b last=%b, want 0", d, cyc, s, l);
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, c_sum, c_first, c_last, c_ovf);
    mon_step(1, n_sum, n_first, n_last, n_ovf);
  end

  task automatic chk_zero(input string nm, input logic [3:0] got);
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b, want 0000", nm, cyc, got);
    end
  endtask

  // Drive nbits of a word; queue the expected result at bit 0 if requested.
  task automatic drive_word(input logic ws, input logic sb,
                            input logic [WL-1:0] av, input logic [WL-1:0] bv,
                            input int nbits, input bit push_c, input bit push_n,
                            input logic [WL-1:0] er, input logic eo,
                            output int t_last);
    exp_t e;
    t_last = cyc;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      word_start = ws && (i == 0);
      sub = sb;
      a = av[i];
      b = bv[i];
      if (i == 0) begin
        e.res   = er;
        e.ovf   = eo;
        e.first = cyc + int'(DL);
        if (push_c) q_c.push_back(e);
        if (push_n) q_n.push_back(e);
      end
      t_last = cyc;
      @(posedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl;
    logic [WL-1:0] ones;
    ones = '1;

    // Reset with word_start high: must be ignored.
    rst_n = 1'b0;
    word_start = 1'b1;
    @(negedge clk);
    chk_zero("reset_out_c", {c_sum, c_first, c_last, c_ovf});
    chk_zero("reset_out_n", {n_sum, n_first, n_last, n_ovf});
    @(negedge clk);
    word_start = 1'b0;
    rst_n = 1'b1;
    while (cyc < 9) begin
      @(negedge clk);
      chk_zero("idle_out_c", {c_sum, c_first, c_last, c_ovf});
      chk_zero("idle_out_n", {n_sum, n_first, n_last, n_ovf});
    end

    // Back-to-back words, word_start on each (both instances).
    drive_word(1'b1, 1'b0, 17'h00005, 17'h00003, WL, 1'b1, 1'b1, 17'h00008, 1'b0, tl);
    drive_word(1'b1, 1'b1, 17'h00003, 17'h00005, WL, 1'b1, 1'b1, 17'h1FFFE, 1'b0, tl);
    drive_word(1'b1, 1'b1, 17'h10000, 17'h00001, WL, 1'b1, 1'b1, 17'h0FFFF, 1'b1, tl);
    drive_word(1'b1, 1'b0, 17'h0FFFF, 17'h00001, WL, 1'b1, 1'b1, 17'h10000, 1'b1, tl);
    drive_word(1'b1, 1'b0, 17'h1FFFF, 17'h00001, WL, 1'b1, 1'b1, 17'h00000, 1'b0, tl);
    // Automatic wrap: no word_start, carry from previous word must not leak.
    drive_word(1'b0, 1'b0, 17'h00000, 17'h00000, WL, 1'b1, 1'b0, 17'h00000, 1'b0, tl);

    // Abort at bit 9 with a=b=1 throughout.
    drive_word(1'b1, 1'b0, ones, ones, 9, 1'b0, 1'b0, 17'h00000, 1'b0, tl);
    drive_word(1'b1, 1'b0, ones, ones, WL, 1'b1, 1'b1, 17'h1FFFE, 1'b0, tl);

    // Reset mid-word discards the word.
    drive_word(1'b1, 1'b1, 17'h000AB, 17'h00013, 6, 1'b0, 1'b0, 17'h00000, 1'b0, tl);
    @(negedge clk);
    rst_n = 1'b0;
    word_start = 1'b1;
    a = 1'b1;
    b = 1'b1;
    @(negedge clk);
    chk_zero("reset_mid_c", {c_sum, c_first, c_last, c_ovf});
    chk_zero("reset_mid_n", {n_sum, n_first, n_last, n_ovf});
    rst_n = 1'b1;
    word_start = 1'b0;
    a = 1'b0;
    b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_zero("post_reset_c", {c_sum, c_first, c_last, c_ovf});
      chk_zero("post_reset_n", {n_sum, n_first, n_last, n_ovf});
    end

    // Final word, then silence: non-continuous instance must go quiet.
    drive_word(1'b1, 1'b0, 17'h1FFFC, 17'h00007, WL, 1'b1, 1'b1, 17'h00003, 1'b0, tl);
    @(negedge clk);
    word_start = 1'b0;
    a = 1'b0;
    b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    mon_en[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk_zero("nc_idle", {n_sum, n_first, n_last, n_ovf});
    end

    checks++;
    if (q_c.size() != 0) begin
      errors++;
      $display("FAIL drain_c: got %0d pending words, want 0", q_c.size());
    end
    checks++;
    if (q_n.size() != 0) begin
      errors++;
      $display("FAIL drain_n: got %0d pending words, want 0", q_n.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
